// File: rtl/bmu_pkg.sv
// Shared types and constants for the PEXT/PDEP bit-manipulation unit.
package bmu_pkg;
  localparam int BMU_W    = 256;
  localparam int BMU_NSTG = 8;
  localparam int BMU_HALF = BMU_W / 2;

  typedef enum logic { BMU_PEXT = 1'b0, BMU_PDEP = 1'b1 } bmu_op_e;
  typedef enum logic [1:0] { ST_IDLE, ST_DECODE, ST_RUN, ST_DONE } bmu_state_e;
  typedef logic [BMU_NSTG-1:0][BMU_HALF-1:0] bmu_cfg_t;

  // Low bit position of pair j in stage s: the j-th index whose bit s is clear.
  function automatic int unsigned pair_lo(input int unsigned s, input int unsigned j);
    return ((j >> s) << (s + 1)) | (j & ((32'd1 << s) - 32'd1));
  endfunction
endpackage

// File: rtl/bfly_stage.sv
// One combinational butterfly stage: conditionally swaps 128 bit pairs at distance 2^stg.
module bfly_stage
  import bmu_pkg::*;
#(
  parameter int unsigned STAGE = 0,
  parameter bit          INV   = 1'b1
) (
  input  logic [2:0]          base,
  input  logic                rev,
  output logic [2:0]          stg,
  input  logic [BMU_HALF-1:0] cfg,
  input  logic [BMU_W-1:0]    d,
  output logic [BMU_W-1:0]    q
);
  logic [2:0] idx;

  assign idx = base + 3'(STAGE);
  // With INV set the stages ascend (inverse butterfly) and rev walks them downward.
  assign stg = (rev == INV) ? 3'd7 - idx : idx;

  always_comb begin
    logic [7:0] lo;
    logic [7:0] hi;
    logic [6:0] jb;
    q  = d;
    lo = '0;
    hi = '0;
    jb = '0;
    for (int unsigned s = 0; s < BMU_NSTG; s++) begin
      if (stg == 3'(s)) begin
        for (int unsigned j = 0; j < BMU_HALF; j++) begin
          jb = 7'(j);
          lo = 8'(pair_lo(s, j));
          hi = lo + 8'(32'd1 << s);
          if (cfg[jb]) begin
            q[lo] = d[hi];
            q[hi] = d[lo];
          end
        end
      end
    end
  end
endmodule

// File: rtl/bmu_mask_dec.sv
// Combinational mask decoder: turns a 256-bit mask into the eight inverse-butterfly
// stage configurations that compress the selected bits down to the LSBs.
module bmu_mask_dec
  import bmu_pkg::*;
(
  input  logic [BMU_W-1:0] mask,
  output bmu_cfg_t         cfg
);
  // A selected bit at p with rank r sits at {p[7:s], r[s-1:0]} entering stage s;
  // that stage swaps its pair exactly when bit s has to change from p[s] to r[s].
  always_comb begin
    logic [8:0] rank;
    logic [7:0] pos;
    logic [7:0] rnk;
    logic [6:0] j;
    logic [2:0] sb;
    // NOTE: every output gets a default before the loops, so no path leaves cfg unassigned and no latch is inferred.
    cfg  = '0;
    rank = '0;
    pos  = '0;
    rnk  = '0;
    j    = '0;
    sb   = '0;
    for (int p = 0; p < BMU_W; p++) begin
      pos = 8'(p);
      rnk = rank[7:0];
      if (mask[pos]) begin
        for (int s = 0; s < BMU_NSTG; s++) begin
          sb = 3'(s);
          j  = 7'(((int'(pos) >> (s + 1)) << s) | (int'(rnk) & ((1 << s) - 1)));
          cfg[sb][j] = cfg[sb][j] | (rnk[sb] != pos[sb]);
        end
        rank = rank + 9'd1;
      end
    end
  end
endmodule

// File: rtl/bmu_pext_seq.sv
// Multi-cycle PEXT/PDEP sequencer: decode the mask once, then apply SPC butterfly
// stages per cycle; a one-entry cache skips decode when the mask repeats.
module bmu_pext_seq
  import bmu_pkg::*;
#(
  parameter int unsigned SPC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [BMU_W-1:0] in_src,
  input  logic [BMU_W-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BMU_W-1:0] out_data,
  output logic             cache_hit
);
  if (!(SPC == 1 || SPC == 2 || SPC == 4 || SPC == 8)) begin : g_bad_spc
    $error("bmu_pext_seq: SPC must be 1, 2, 4 or 8");
  end

  localparam logic [3:0] SPC_STEP = 4'(SPC);

  bmu_state_e       state_q, state_d;
  bmu_op_e          op_q;
  logic [BMU_W-1:0] mask_q, data_q, cache_mask, run_out, run_res;
  logic [3:0]       stage_cnt;
  bmu_cfg_t         cfg_q, dec_cfg;
  logic             cache_vld, cache_hit_q, accept, hit, last;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign hit      = cache_vld && (cache_mask == in_mask);
  assign last     = (stage_cnt + SPC_STEP) == 4'd8;

  bmu_mask_dec u_dec (
    .mask (mask_q),
    .cfg  (dec_cfg)
  );

  for (genvar k = 0; k < SPC; k++) begin : g_slot
    logic [BMU_W-1:0] din, dout;
    logic [2:0]       stg;
    if (k == 0) begin : g_first
      assign din = data_q;
    end else begin : g_next
      assign din = g_slot[k-1].dout;
    end
    bfly_stage #(.STAGE(k), .INV(1'b1)) u_stage (
      .base (stage_cnt[2:0]),
      .rev  (op_q == BMU_PDEP),
      .stg  (stg),
      .cfg  (cfg_q[stg]),
      .d    (din),
      .q    (dout)
    );
  end
  assign run_out = g_slot[SPC-1].dout;

  // PDEP leaves junk in unselected positions until the final mask.
  assign run_res = (last && op_q == BMU_PDEP) ? (run_out & mask_q) : run_out;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = hit ? ST_RUN : ST_DECODE;
      ST_DECODE: state_d = ST_RUN;
      ST_RUN:    if (last) state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= BMU_PEXT;
      data_q      <= '0;
      stage_cnt   <= '0;
      cache_vld   <= 1'b0;
      cache_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cache_hit_q <= accept && hit;
      if (accept) begin
        op_q      <= bmu_op_e'(in_op);
        data_q    <= in_op ? in_src : (in_src & in_mask);
        stage_cnt <= '0;
      end else if (state_q == ST_RUN && !flush) begin
        data_q    <= run_res;
        stage_cnt <= stage_cnt + SPC_STEP;
      end
      if (state_q == ST_DECODE && !flush) cache_vld <= 1'b1;
    end
  end

  // NOTE: the mask and config cache carry no reset; cache_vld alone qualifies them.
  always_ff @(posedge clk) begin
    if (accept) mask_q <= in_mask;
    if (state_q == ST_DECODE && !flush) begin
      cfg_q      <= dec_cfg;
      cache_mask <= mask_q;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign cache_hit = cache_hit_q;
endmodule

// File: doc/bmu_pext_seq.md
# bmu_pext_seq

Multi-cycle sequencer for the 256-bit bit-extract/deposit (PEXT/PDEP) unit in the bit-manipulation pipeline. Accepts one operation at a time over a valid/ready handshake, drives the mask decoder to obtain the eight 128-bit inverse-butterfly stage configurations, and applies the butterfly stages over several cycles. A one-entry mask cache skips decode for back-to-back operations that use the same mask.

## Interface
- `SPC`, default 2: butterfly stages applied per RUN cycle. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous kill of the in-flight operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when high together with `in_valid`.
- `in_op` input 1: 0 = PEXT, 1 = PDEP.
- `in_src` input 256: source operand.
- `in_mask` input 256: bit mask.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer ready.
- `out_data` output 256: result.
- `cache_hit` output 1: one-cycle pulse in the cycle after accept when the decode step was skipped.

## Operation
- **States:** IDLE, DECODE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1; this is the only state in which `in_ready` is 1.
  - On accept, latch `op`, `mask` and `data`. PEXT latches `data = src & mask`; PDEP latches `data = src`.
  - Cache hit (`cache_vld && cache_mask == in_mask`): go to RUN with `stage_cnt = 0`.
  - Cache miss: go to DECODE.
- **DECODE (1 cycle)**
  - Feed the latched mask to the mask decoder.
  - Register `cfg0..cfg7` into the cache; set `cache_mask` to the mask and `cache_vld = 1`.
  - Go to RUN.
- **RUN**
  - Each cycle applies SPC stages, then `stage_cnt += SPC`.
  - PEXT uses the inverse butterfly, stages 0→7 with `cfg[s]`.
  - PDEP uses the butterfly, stages 7→0 with `cfg[s]`, then a final AND with the mask in the last RUN cycle.
  - After the RUN cycle in which `stage_cnt + SPC == 8`, go to DONE.
- **DONE**
  - `out_valid` = 1 and `out_data` holds stable.
  - On `out_ready`, go to IDLE.
- **Stage semantics:** stage s swaps bit pairs at distance 2^s. Pair index j, 0..127, selects bit positions i and i + 2^s, where i is the j-th position with bit s clear. The pair is swapped when `cfg[s][j] = 1`.
- **Flush:** in any state, `flush` forces IDLE on the next edge and clears `out_valid`. The cache is retained if DECODE had already completed. A flush during DECODE leaves `cache_vld` unchanged.
- **Flush and accept in the same cycle:** flush wins and the request is not accepted.
- **Reset:** `cache_vld` = 0, state = IDLE, `out_valid` = 0, `out_data` = 0, `in_ready` = 1 once reset is released, `cache_hit` = 0.
- **Edge-case masks:** none are special-cased. An all-zero mask yields 0; an all-ones mask yields `src`.

## Timing
- Accept at edge T.
  - Miss: DECODE in cycle T+1, RUN in T+2 … T+1+8/SPC, `out_valid` from T+2+8/SPC. With SPC = 2, `out_valid` rises at T+6.
  - Hit: RUN starts at T+1 and `out_valid` rises at T+1+8/SPC. With SPC = 2, `out_valid` rises at T+5.
- Backpressure: `out_valid` stays high for as long as `out_ready` = 0. The next accept occurs no earlier than one cycle after the output handshake.
- The mask decoder is purely combinational. The DECODE register stage is the only timing break on the decode path.

## Structure
- Shared package `bmu_pkg`:
  - `bmu_op_e` (PEXT, PDEP).
  - `bmu_state_e`.
  - `BMU_W = 256`.
  - `BMU_NSTG = 8`.
  - `bmu_cfg_t`, defined as `logic [7:0][127:0]`.
- Sub-module `bfly_stage`:
  - Parameters: `STAGE` and `INV`.
  - Behaviour: combinational, one 256-bit stage with a 128-bit config input.
  - Instantiation: SPC instances are chained; the per-instance stage index is muxed by `stage_cnt` and `op`.
- The mask decoder is instantiated once, inside the sequencer.

## Test plan
- **PEXT, cache miss:** `mask = 0xFF00`, `src = 0xAB00` → `out_data = 0xAB`; `out_valid` at T+6 (SPC = 2); `cache_hit` = 0.
- **PDEP, cache miss:** `mask = 0xF0F0`, `src = 0xAB` → `out_data = 0xA0B0`.
- **Cache hit:** repeat a PEXT with `mask = 0xF0F0`, `src = 0xA0B0` → `out_data = 0xAB`; `cache_hit` pulses; latency is T+5.
- **Masks all-ones and zero:** all-ones with random `src` → `out_data == src` for both ops; `mask = 0` → `out_data = 0`.
- **Backpressure then flush:** hold `out_ready = 0` for 10 cycles → `out_data` stable and `in_ready` = 0. Flush during RUN → `out_valid` never rises and IDLE is reached the next cycle. A following request with the same mask shows `cache_hit` only if DECODE had completed.
- **Async reset mid-RUN:** outputs go to their reset values immediately. The first request after reset misses the cache.
